// File: rtl/vrf_pkg.sv
// ---------------------------------------------------------------------------
// vrf_pkg: shared encodings and helpers for the vec_regfile slice
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vrf_pkg;

  localparam logic [1:0] OP_SS   = 2'b00;
  localparam logic [1:0] OP_SV   = 2'b01;
  localparam logic [1:0] OP_NONE = 2'b10;
  localparam logic [1:0] OP_VV   = 2'b11;

  typedef enum logic {
    REG_S = 1'b0,
    REG_V = 1'b1
  } reg_class_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int max_regs(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vrf_scoreboard.sv
// ---------------------------------------------------------------------------
// vrf_scoreboard: pending-write bits per register and RAW hazard lookup
// rev 1.0 -- hazard suppression on same-cycle write under VRF_BYPASS_EN
// ---------------------------------------------------------------------------
`default_nettype none

module vrf_scoreboard
  import vrf_pkg::*;
#(
  parameter int NUM_SREG = 16,
  parameter int NUM_VREG = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ready,
  input  logic              iss_en,
  input  logic              iss_type,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              wr_en,
  input  logic              wr_type,
  input  logic [ADDR_W-1:0] wa,
  input  logic [1:0]        rd_type,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic              hz1,
  output logic              hz2
);

  localparam logic [ADDR_W:0] S_LIM = (ADDR_W+1)'(NUM_SREG);
  localparam logic [ADDR_W:0] V_LIM = (ADDR_W+1)'(NUM_VREG);

  logic [NUM_SREG-1:0] s_pend;
  logic [NUM_VREG-1:0] v_pend;

  logic set_s, set_v, clr_s, clr_v;
  assign set_s = ready && iss_en && (iss_type == REG_S);
  assign set_v = ready && iss_en && (iss_type == REG_V);
  assign clr_s = ready && wr_en  && (wr_type  == REG_S);
  assign clr_v = ready && wr_en  && (wr_type  == REG_V);

  // A fresh issue to the register being retired keeps it pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_pend <= '0;
      v_pend <= '0;
    end else begin
      for (int i = 0; i < NUM_SREG; i++) begin
        if (set_s && (iss_addr == ADDR_W'(i)))
          s_pend[i] <= 1'b1;
        else if (clr_s && (wa == ADDR_W'(i)))
          s_pend[i] <= 1'b0;
      end
      for (int i = 0; i < NUM_VREG; i++) begin
        if (set_v && (iss_addr == ADDR_W'(i)))
          v_pend[i] <= 1'b1;
        else if (clr_v && (wa == ADDR_W'(i)))
          v_pend[i] <= 1'b0;
      end
    end
  end

  logic op1_v, op2_v, p1, p2, byp1, byp2;

  always_comb begin
    op1_v = (rd_type == OP_VV);
    op2_v = (rd_type != OP_SS);
    p1    = 1'b0;
    p2    = 1'b0;
    if (op1_v) begin
      if ({1'b0, ra1} < V_LIM) p1 = v_pend[ra1];
    end else if ({1'b0, ra1} < S_LIM) begin
      p1 = s_pend[ra1];
    end
    if (op2_v) begin
      if ({1'b0, ra2} < V_LIM) p2 = v_pend[ra2];
    end else if ({1'b0, ra2} < S_LIM) begin
      p2 = s_pend[ra2];
    end
`ifdef VRF_BYPASS_EN
    byp1 = wr_en && (wr_type == op1_v) && (wa == ra1);
    byp2 = wr_en && (wr_type == op2_v) && (wa == ra2);
`else
    byp1 = 1'b0;
    byp2 = 1'b0;
`endif
    hz1 = ready && (rd_type != OP_NONE) && p1 && !byp1;
    hz2 = ready && (rd_type != OP_NONE) && p2 && !byp2;
  end

endmodule

`default_nettype wire

// File: rtl/vec_regfile.sv
// ---------------------------------------------------------------------------
// vec_regfile: scalar/vector register file, 2R1W, lane-masked writes, init sweep
// rev 1.0 -- same-cycle write-to-read forwarding under VRF_BYPASS_EN
// ---------------------------------------------------------------------------
`default_nettype none

module vec_regfile
  import vrf_pkg::*;
#(
  parameter int LANES    = 8,
  parameter int LANE_W   = 24,
  parameter int SCALAR_W = 24,
  parameter int NUM_SREG = 16,
  parameter int NUM_VREG = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    ready,
  input  logic                    rd_en,
  input  logic [1:0]              rd_type,
  input  logic [ADDR_W-1:0]       ra1,
  input  logic [ADDR_W-1:0]       ra2,
  output logic                    rd_valid,
  output logic [SCALAR_W-1:0]     r1s,
  output logic [SCALAR_W-1:0]     r2s,
  output logic [LANES*LANE_W-1:0] r1v,
  output logic [LANES*LANE_W-1:0] r2v,
  input  logic                    wr_en,
  input  logic                    wr_type,
  input  logic [ADDR_W-1:0]       wa,
  input  logic [SCALAR_W-1:0]     wds,
  input  logic [LANES*LANE_W-1:0] wdv,
  input  logic [LANES-1:0]        wr_mask,
  input  logic                    iss_en,
  input  logic                    iss_type,
  input  logic [ADDR_W-1:0]       iss_addr,
  output logic                    hz1,
  output logic                    hz2
);

  localparam int              VEC_W    = LANES * LANE_W;
  localparam int              MAXR     = max_regs(NUM_SREG, NUM_VREG);
  localparam logic [ADDR_W:0] S_LIM    = (ADDR_W+1)'(NUM_SREG);
  localparam logic [ADDR_W:0] V_LIM    = (ADDR_W+1)'(NUM_VREG);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(MAXR - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] idx;

  logic [SCALAR_W-1:0] s_mem [NUM_SREG];
  logic [VEC_W-1:0]    v_mem [NUM_VREG];

  // ---------------- init / run control ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_INIT: if (idx == IDX_LAST) state_nx = ST_RUN;
      ST_RUN:  state_nx = ST_RUN;
      default: state_nx = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      idx <= '0;
    else if ((state == ST_INIT) && (idx != IDX_LAST))
      idx <= idx + ADDR_W'(1);
  end

  assign ready = (state == ST_RUN);

  // ---------------- storage ----------------
  logic wr_s, wr_v;
  assign wr_s = rst_n && ready && wr_en && (wr_type == REG_S) && ({1'b0, wa} < S_LIM);
  assign wr_v = rst_n && ready && wr_en && (wr_type == REG_V) && ({1'b0, wa} < V_LIM);

  // Storage has no reset of its own; the INIT sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      if ({1'b0, idx} < S_LIM) s_mem[idx] <= '0;
      if ({1'b0, idx} < V_LIM) v_mem[idx] <= '0;
    end else begin
      if (wr_s) s_mem[wa] <= wds;
      if (wr_v) begin
        for (int i = 0; i < LANES; i++) begin
          if (wr_mask[i])
            v_mem[wa][i*LANE_W +: LANE_W] <= wdv[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // ---------------- read operand selection ----------------
  logic                s_hit1, s_hit2, v_hit1, v_hit2;
  logic [SCALAR_W-1:0] s_raw1, s_raw2, s_rd1, s_rd2;
  logic [VEC_W-1:0]    v_raw1, v_raw2, v_rd1, v_rd2;

  always_comb begin
    s_raw1 = ({1'b0, ra1} < S_LIM) ? s_mem[ra1] : '0;
    s_raw2 = ({1'b0, ra2} < S_LIM) ? s_mem[ra2] : '0;
    v_raw1 = ({1'b0, ra1} < V_LIM) ? v_mem[ra1] : '0;
    v_raw2 = ({1'b0, ra2} < V_LIM) ? v_mem[ra2] : '0;
`ifdef VRF_BYPASS_EN
    s_hit1 = wr_s && (wa == ra1);
    s_hit2 = wr_s && (wa == ra2);
    v_hit1 = wr_v && (wa == ra1);
    v_hit2 = wr_v && (wa == ra2);
`else
    s_hit1 = 1'b0;
    s_hit2 = 1'b0;
    v_hit1 = 1'b0;
    v_hit2 = 1'b0;
`endif
    s_rd1 = s_hit1 ? wds : s_raw1;
    s_rd2 = s_hit2 ? wds : s_raw2;
  end

  // Forwarded vector data only replaces the lanes the write actually touches.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign v_rd1[i*LANE_W +: LANE_W] = (v_hit1 && wr_mask[i]) ?
                                       wdv[i*LANE_W +: LANE_W] : v_raw1[i*LANE_W +: LANE_W];
    assign v_rd2[i*LANE_W +: LANE_W] = (v_hit2 && wr_mask[i]) ?
                                       wdv[i*LANE_W +: LANE_W] : v_raw2[i*LANE_W +: LANE_W];
  end

  logic rd_fire;
  assign rd_fire = ready && rd_en && (rd_type != OP_NONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      r1s      <= '0;
      r2s      <= '0;
      r1v      <= '0;
      r2v      <= '0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) begin
        case (rd_type)
          OP_SS: begin
            r1s <= s_rd1;
            r2s <= s_rd2;
          end
          OP_SV: begin
            r1s <= s_rd1;
            r2v <= v_rd2;
          end
          OP_VV: begin
            r1v <= v_rd1;
            r2v <= v_rd2;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- hazard scoreboard ----------------
  vrf_scoreboard #(
    .NUM_SREG (NUM_SREG),
    .NUM_VREG (NUM_VREG),
    .ADDR_W   (ADDR_W)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready),
    .iss_en   (iss_en),
    .iss_type (iss_type),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_type  (wr_type),
    .wa       (wa),
    .rd_type  (rd_type),
    .ra1      (ra1),
    .ra2      (ra2),
    .hz1      (hz1),
    .hz2      (hz2)
  );

endmodule

`default_nettype wire

// File: tb/tb_vec_regfile.sv
// ---------------------------------------------------------------------------
// tb_vec_regfile: directed table, corner sequences and randomized model check
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vec_regfile;

  localparam int LANES = 8;
  localparam int LW    = 24;
  localparam int VEC_W = LANES * LW;
  localparam int NR    = 16;
  localparam int AW    = 4;

`ifdef VRF_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ready;
  logic             rd_en;
  logic [1:0]       rd_type;
  logic [AW-1:0]    ra1, ra2;
  logic             rd_valid;
  logic [LW-1:0]    r1s, r2s;
  logic [VEC_W-1:0] r1v, r2v;
  logic             wr_en, wr_type;
  logic [AW-1:0]    wa;
  logic [LW-1:0]    wds;
  logic [VEC_W-1:0] wdv;
  logic [LANES-1:0] wr_mask;
  logic             iss_en, iss_type;
  logic [AW-1:0]    iss_addr;
  logic             hz1, hz2;

  always #5 clk = ~clk;

  vec_regfile #(
    .LANES(LANES), .LANE_W(LW), .SCALAR_W(LW),
    .NUM_SREG(NR), .NUM_VREG(NR), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .rd_en(rd_en), .rd_type(rd_type), .ra1(ra1), .ra2(ra2),
    .rd_valid(rd_valid), .r1s(r1s), .r2s(r2s), .r1v(r1v), .r2v(r2v),
    .wr_en(wr_en), .wr_type(wr_type), .wa(wa), .wds(wds), .wdv(wdv), .wr_mask(wr_mask),
    .iss_en(iss_en), .iss_type(iss_type), .iss_addr(iss_addr),
    .hz1(hz1), .hz2(hz2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chkv(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chkv(name, VEC_W'(act), VEC_W'(exp));
  endtask

  task automatic chks(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    chkv(name, VEC_W'(act), VEC_W'(exp));
  endtask

  function automatic logic [VEC_W-1:0] mkvec(input logic [LW-1:0] lo, input logic [LW-1:0] hi);
    logic [VEC_W-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*LW +: LW] = (l < LANES/2) ? lo : hi;
    return v;
  endfunction

  task automatic idle();
    rd_en = 1'b0; rd_type = 2'b10; ra1 = '0; ra2 = '0;
    wr_en = 1'b0; wr_type = 1'b0; wa = '0; wds = '0; wdv = '0; wr_mask = '0;
    iss_en = 1'b0; iss_type = 1'b0; iss_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    chkv(name, VEC_W'(n), VEC_W'(16));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          wen;
    logic          wt;
    logic [AW-1:0] wa;
    logic [LW-1:0] wd;
    logic [7:0]    mask;
    logic          ren;
    logic [1:0]    rt;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic          ev;
    logic [LW-1:0] e1s, e2s, e1lo, e1hi, e2lo, e2hi;
  } row_t;

  row_t tbl[13];

  // ---------------- reference model ----------------
  logic [LW-1:0] s_ref [NR];
  logic [LW-1:0] v_ref [NR][LANES];
  logic          ps [NR];
  logic          pv [NR];
  logic          e_valid;
  logic [LW-1:0] e1s, e2s;
  logic [VEC_W-1:0] e1v, e2v;

  function automatic logic model_hz(input logic vec, input logic [AW-1:0] a);
    logic p;
    p = vec ? pv[a] : ps[a];
    if (BYP && wr_en && (wr_type == vec) && (wa == a)) p = 1'b0;
    return p;
  endfunction

  function automatic logic [LW-1:0] model_s(input logic [AW-1:0] a);
    if (BYP && wr_en && !wr_type && wa == a) return wds;
    return s_ref[a];
  endfunction

  function automatic logic [VEC_W-1:0] model_v(input logic [AW-1:0] a);
    logic [VEC_W-1:0] v;
    for (int l = 0; l < LANES; l++) begin
      if (BYP && wr_en && wr_type && wa == a && wr_mask[l]) v[l*LW +: LW] = wdv[l*LW +: LW];
      else                                                  v[l*LW +: LW] = v_ref[a][l];
    end
    return v;
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NR-1));
    return AW'($urandom_range(0, 3));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1,1'b0,4'd3,24'h00ABCD,8'h00, 1'b0,2'b00,4'd0,4'd0, 1'b0,24'h0,24'h0,24'h0,24'h0,24'h0,24'h0};
    tbl[1]  = '{1'b0,1'b0,4'd0,24'h0,8'h00,      1'b1,2'b00,4'd3,4'd0, 1'b1,24'h00ABCD,24'h0,24'h0,24'h0,24'h0,24'h0};
    tbl[2]  = '{1'b0,1'b0,4'd0,24'h0,8'h00,      1'b0,2'b00,4'd0,4'd0, 1'b0,24'h00ABCD,24'h0,24'h0,24'h0,24'h0,24'h0};
    tbl[3]  = '{1'b1,1'b1,4'd2,24'h111111,8'hFF, 1'b0,2'b00,4'd0,4'd0, 1'b0,24'h00ABCD,24'h0,24'h0,24'h0,24'h0,24'h0};
    tbl[4]  = '{1'b1,1'b1,4'd2,24'h222222,8'h0F, 1'b0,2'b00,4'd0,4'd0, 1'b0,24'h00ABCD,24'h0,24'h0,24'h0,24'h0,24'h0};
    tbl[5]  = '{1'b0,1'b0,4'd0,24'h0,8'h00,      1'b1,2'b11,4'd2,4'd2, 1'b1,24'h00ABCD,24'h0,24'h222222,24'h111111,24'h222222,24'h111111};
    tbl[6]  = '{1'b0,1'b0,4'd0,24'h0,8'h00,      1'b1,2'b01,4'd3,4'd5, 1'b1,24'h00ABCD,24'h0,24'h222222,24'h111111,24'h0,24'h0};
    tbl[7]  = '{1'b0,1'b0,4'd0,24'h0,8'h00,      1'b1,2'b10,4'd3,4'd2, 1'b0,24'h00ABCD,24'h0,24'h222222,24'h111111,24'h0,24'h0};
    tbl[8]  = '{1'b1,1'b0,4'd4,24'h00005A,8'h00, 1'b1,2'b00,4'd4,4'd3, 1'b1,(BYP ? 24'h5A : 24'h0),24'h00ABCD,24'h222222,24'h111111,24'h0,24'h0};
    tbl[9]  = '{1'b0,1'b0,4'd0,24'h0,8'h00,      1'b1,2'b00,4'd4,4'd4, 1'b1,24'h5A,24'h5A,24'h222222,24'h111111,24'h0,24'h0};
    tbl[10] = '{1'b0,1'b0,4'd0,24'h0,8'h00,      1'b1,2'b00,4'd5,4'd0, 1'b1,24'h0,24'h0,24'h222222,24'h111111,24'h0,24'h0};
    tbl[11] = '{1'b1,1'b1,4'd2,24'h333333,8'h00, 1'b1,2'b11,4'd2,4'd5, 1'b1,24'h0,24'h0,24'h222222,24'h111111,24'h0,24'h0};
    tbl[12] = '{1'b0,1'b0,4'd0,24'h0,8'h00,      1'b1,2'b11,4'd5,4'd2, 1'b1,24'h0,24'h0,24'h0,24'h0,24'h222222,24'h111111};

    // ---- reset and init sweep ----
    idle();
    rst_n = 1'b0;
    repeat (3) tick();
    chkb("reset ready", ready, 1'b0);
    chkb("reset rd_valid", rd_valid, 1'b0);
    chks("reset r1s", r1s, '0);
    chks("reset r2s", r2s, '0);
    chkv("reset r1v", r1v, '0);
    chkv("reset r2v", r2v, '0);
    chkb("reset hz1", hz1, 1'b0);
    chkb("reset hz2", hz2, 1'b0);
    rst_n = 1'b1;
    wait_ready("init length");

    // ---- directed table ----
    for (int i = 0; i < 13; i++) begin
      idle();
      wr_en = tbl[i].wen; wr_type = tbl[i].wt; wa = tbl[i].wa;
      wds = tbl[i].wd; wdv = {LANES{tbl[i].wd}}; wr_mask = tbl[i].mask;
      rd_en = tbl[i].ren; rd_type = tbl[i].rt; ra1 = tbl[i].a1; ra2 = tbl[i].a2;
      tick();
      chkb($sformatf("row%0d rd_valid", i), rd_valid, tbl[i].ev);
      chks($sformatf("row%0d r1s", i), r1s, tbl[i].e1s);
      chks($sformatf("row%0d r2s", i), r2s, tbl[i].e2s);
      chkv($sformatf("row%0d r1v", i), r1v, mkvec(tbl[i].e1lo, tbl[i].e1hi));
      chkv($sformatf("row%0d r2v", i), r2v, mkvec(tbl[i].e2lo, tbl[i].e2hi));
    end

    // ---- scoreboard sequences ----
    idle();
    iss_en = 1'b1; iss_type = 1'b1; iss_addr = 4'd7;
    tick();
    idle();
    rd_type = 2'b01; ra1 = 4'd7; ra2 = 4'd7;
    #1;
    chkb("sb issue hz2", hz2, 1'b1);
    chkb("sb issue hz1", hz1, 1'b0);
    wr_en = 1'b1; wr_type = 1'b1; wa = 4'd7; wdv = mkvec(24'h777777, 24'h777777); wr_mask = 8'hFF;
    #1;
    chkb("sb write-cycle hz2", hz2, !BYP);
    tick();
    wr_en = 1'b0;
    #1;
    chkb("sb cleared hz2", hz2, 1'b0);
    iss_en = 1'b1; iss_type = 1'b1; iss_addr = 4'd7;
    wr_en = 1'b1; wr_type = 1'b1; wa = 4'd7;
    tick();
    iss_en = 1'b0; wr_en = 1'b0;
    #1;
    chkb("sb set wins hz2", hz2, 1'b1);
    iss_en = 1'b1; iss_type = 1'b0; iss_addr = 4'd1;
    tick();
    iss_en = 1'b0;
    rd_type = 2'b00; ra1 = 4'd1; ra2 = 4'd7;
    #1;
    chkb("sb scalar hz1", hz1, 1'b1);
    chkb("sb scalar-class hz2", hz2, 1'b0);
    rd_type = 2'b10;
    #1;
    chkb("sb none hz1", hz1, 1'b0);
    chkb("sb none hz2", hz2, 1'b0);

    // ---- reset while pending and a read in flight ----
    rd_en = 1'b1; rd_type = 2'b00; ra1 = 4'd3; ra2 = 4'd4;
    tick();
    chks("pre-reset r1s", r1s, 24'h00ABCD);
    chks("pre-reset r2s", r2s, 24'h5A);
    ra1 = 4'd1;
    rst_n = 1'b0;
    tick();
    chkb("midrst ready", ready, 1'b0);
    chkb("midrst rd_valid", rd_valid, 1'b0);
    chks("midrst r1s", r1s, '0);
    chks("midrst r2s", r2s, '0);
    chkv("midrst r1v", r1v, '0);
    chkv("midrst r2v", r2v, '0);
    chkb("midrst hz1", hz1, 1'b0);
    rst_n = 1'b1;
    wait_ready("reinit length");
    chkb("reinit rd_valid", rd_valid, 1'b0);
    idle();
    rd_type = 2'b00; ra1 = 4'd1;
    #1;
    chkb("reinit pend S1", hz1, 1'b0);
    rd_type = 2'b11; ra2 = 4'd7;
    #1;
    chkb("reinit pend V7", hz2, 1'b0);
    rd_en = 1'b1; rd_type = 2'b00; ra1 = 4'd3; ra2 = 4'd4;
    tick();
    chkb("reinit read valid", rd_valid, 1'b1);
    chks("reinit S3 zero", r1s, '0);
    chks("reinit S4 zero", r2s, '0);

    // ---- randomized run against the model ----
    for (int r = 0; r < NR; r++) begin
      s_ref[r] = '0;
      ps[r] = 1'b0;
      pv[r] = 1'b0;
      for (int l = 0; l < LANES; l++) v_ref[r][l] = '0;
    end
    e1s = '0; e2s = '0; e1v = '0; e2v = '0;
    for (int n = 0; n < 400; n++) begin
      rd_en    = 1'($urandom_range(0, 1));
      rd_type  = 2'($urandom);
      ra1      = rnd_addr();
      ra2      = rnd_addr();
      wr_en    = ($urandom_range(0, 2) != 0);
      wr_type  = 1'($urandom);
      wa       = rnd_addr();
      wds      = LW'($urandom);
      for (int l = 0; l < LANES; l++) wdv[l*LW +: LW] = LW'($urandom);
      wr_mask  = LANES'($urandom);
      iss_en   = ($urandom_range(0, 3) == 0);
      iss_type = 1'($urandom);
      iss_addr = rnd_addr();
      #1;
      chkb("rnd hz1", hz1, (rd_type != 2'b10) && model_hz(rd_type == 2'b11, ra1));
      chkb("rnd hz2", hz2, (rd_type != 2'b10) && model_hz(rd_type != 2'b00, ra2));

      e_valid = rd_en && (rd_type != 2'b10);
      if (e_valid) begin
        case (rd_type)
          2'b00:   begin e1s = model_s(ra1); e2s = model_s(ra2); end
          2'b01:   begin e1s = model_s(ra1); e2v = model_v(ra2); end
          default: begin e1v = model_v(ra1); e2v = model_v(ra2); end
        endcase
      end
      if (wr_en) begin
        if (!wr_type) s_ref[wa] = wds;
        else for (int l = 0; l < LANES; l++) if (wr_mask[l]) v_ref[wa][l] = wdv[l*LW +: LW];
        if (wr_type) pv[wa] = 1'b0;
        else         ps[wa] = 1'b0;
      end
      if (iss_en) begin
        if (iss_type) pv[iss_addr] = 1'b1;
        else          ps[iss_addr] = 1'b1;
      end

      tick();
      chkb("rnd rd_valid", rd_valid, e_valid);
      chks("rnd r1s", r1s, e1s);
      chks("rnd r2s", r2s, e2s);
      chkv("rnd r1v", r1v, e1v);
      chkv("rnd r2v", r2v, e2v);
    end

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
